wb_32to128_bridge: RTL

//  Upstream adapter that feeds the 128-bit single-port SRAM wrapper from a 32-bit Wishbone bus.

---
 rtl/wb_32to128_bridge.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_32to128_bridge.sv
// 32-bit Wishbone slave to 128-bit Wishbone master bridge.
// Narrow accesses are steered into one 32-bit lane of a 128-bit line. Writes go
// straight through to the master side. Reads may be served from a one-line buffer.
// Any master access that gets no ack/err within TIMEOUT cycles is aborted with err.
module wb_32to128_bridge #(
  parameter int AW      = 32,
  parameter bit BUF_EN  = 1'b1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  // 32-bit slave side
  input  logic [AW-1:0] i_s_wb_adr,
  input  logic [3:0]    i_s_wb_sel,
  input  logic          i_s_wb_we,
  input  logic [31:0]   i_s_wb_dat,
  output logic [31:0]   o_s_wb_dat,
  input  logic          i_s_wb_cyc,
  input  logic          i_s_wb_stb,
  output logic          o_s_wb_ack,
  output logic          o_s_wb_err,
  // 128-bit master side
  output logic [AW-1:0] o_m_wb_adr,
  output logic [15:0]   o_m_wb_sel,
  output logic          o_m_wb_we,
  output logic [127:0]  o_m_wb_dat,
  input  logic [127:0]  i_m_wb_dat,
  output logic          o_m_wb_cyc,
  output logic          o_m_wb_stb,
  input  logic          i_m_wb_ack,
  input  logic          i_m_wb_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MREQ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The counter's last value before it would reach TIMEOUT.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_state_nxt;

  // Slave-side response registers.
  logic            r_s_ack;
  logic            r_s_err;
  logic [31:0]     r_s_dat;

  // Master-side request registers, held stable for the whole access.
  logic            r_m_cyc;
  logic [AW-1:0]   r_m_adr;
  logic [15:0]     r_m_sel;
  logic            r_m_we;
  logic [127:0]    r_m_dat;
  logic [1:0]      r_lane;
  logic [7:0]      r_cnt;

  // Single-line read buffer.
  logic            r_buf_valid;
  logic [AW-5:0]   r_buf_tag;
  logic [127:0]    r_buf_line;

  // Combinational decode.
  logic [1:0]      w_lane;
  logic            w_req;
  logic            w_hit;
  logic            w_s_live;
  logic            w_m_tag_hit;
  logic            w_start_hit;
  logic            w_start_mreq;
  logic            w_done_ack;
  logic            w_done_err;
  logic            w_done_tmo;
  logic            w_unused;

  assign w_lane   = i_s_wb_adr[3:2];
  // The cycle carrying an ack/err pulse is never taken as a new request.
  assign w_req    = i_s_wb_cyc & i_s_wb_stb & ~r_s_ack & ~r_s_err;
  assign w_hit    = BUF_EN & r_buf_valid & ~i_s_wb_we &
                    (r_buf_tag == i_s_wb_adr[AW-1:4]);
  // A slave that has dropped its request gets no ack/err for it.
  assign w_s_live = i_s_wb_cyc & i_s_wb_stb;
  assign w_m_tag_hit = r_buf_valid & (r_buf_tag == r_m_adr[AW-1:4]);
  // Byte offset bits are irrelevant on a 32-bit bus with byte enables.
  assign w_unused = ^i_s_wb_adr[1:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and one-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_start_hit  = 1'b0;
    w_start_mreq = 1'b0;
    w_done_ack   = 1'b0;
    w_done_err   = 1'b0;
    w_done_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_start_hit = 1'b1;
            w_state_nxt = S_RESP;
          end else begin
            w_start_mreq = 1'b1;
            w_state_nxt  = S_MREQ;
          end
        end
      end
      S_MREQ: begin
        // err wins over a simultaneous ack.
        if (i_m_wb_err) begin
          w_done_err  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (i_m_wb_ack) begin
          w_done_ack  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == TMO_LAST) begin
          w_done_tmo  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, master handshake, slave responses and buffer upkeep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ack     <= 1'b0;
      r_s_err     <= 1'b0;
      r_s_dat     <= '0;
      r_m_cyc     <= 1'b0;
      r_m_adr     <= '0;
      r_m_sel     <= '0;
      r_m_we      <= 1'b0;
      r_m_dat     <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      // NOTE: the buffer line itself is not reset; valid=0 makes its content
      // unreachable, so clearing 128 data flops would buy nothing.
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
    end else begin
      r_s_ack <= 1'b0;
      r_s_err <= 1'b0;

      if (w_start_hit) begin
        r_s_ack <= 1'b1;
        r_s_dat <= r_buf_line[{w_lane, 5'b0} +: 32];
      end

      if (w_start_mreq) begin
        r_m_cyc <= 1'b1;
        r_m_adr <= {i_s_wb_adr[AW-1:4], 4'b0};
        r_m_sel <= {12'b0, i_s_wb_sel} << {w_lane, 2'b00};
        r_m_we  <= i_s_wb_we;
        r_m_dat <= {4{i_s_wb_dat}};
        r_lane  <= w_lane;
        r_cnt   <= '0;
      end

      if (r_state == S_MREQ) r_cnt <= r_cnt + 8'd1;

      if (w_done_ack) begin
        r_m_cyc <= 1'b0;
        r_s_ack <= w_s_live;
        if (!r_m_we) begin
          r_buf_line  <= i_m_wb_dat;
          r_buf_tag   <= r_m_adr[AW-1:4];
          r_buf_valid <= BUF_EN;
          r_s_dat     <= i_m_wb_dat[{r_lane, 5'b0} +: 32];
        end else if (w_m_tag_hit) begin
          // Keep the buffered line coherent with the write just completed.
          for (int b = 0; b < 16; b++) begin
            if (r_m_sel[b]) r_buf_line[8*b +: 8] <= r_m_dat[8*b +: 8];
          end
        end
      end

      if (w_done_err) begin
        r_m_cyc <= 1'b0;
        r_s_err <= w_s_live;
        if (w_m_tag_hit) r_buf_valid <= 1'b0;
      end

      if (w_done_tmo) begin
        r_m_cyc     <= 1'b0;
        r_s_err     <= w_s_live;
        r_buf_valid <= 1'b0;
      end
    end
  end

  assign o_s_wb_dat = r_s_dat;
  assign o_s_wb_ack = r_s_ack;
  assign o_s_wb_err = r_s_err;
  assign o_m_wb_adr = r_m_adr;
  assign o_m_wb_sel = r_m_sel;
  assign o_m_wb_we  = r_m_we;
  assign o_m_wb_dat = r_m_dat;
  assign o_m_wb_cyc = r_m_cyc;
  assign o_m_wb_stb = r_m_cyc;

endmodule
